sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM as two half-word transfers (low half, then high half).
- Drives `ready`. The pipeline registers take `Freeze = ~ready`, which holds IF/ID/EX/MEM/WB stable until the access completes.
- Sits between the MEM stage (`address` = ALU result, `write_data` = Rm value) and the board SRAM pins.

Parameters:
- HALF_CYCLES, 3, clock cycles per 16-bit transfer; legal range 2..15.
- MEM_BASE, 1024, byte address that maps to SRAM word 0.
- ADDR_W, 18, SRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low. Sampled on the clk rising edge; asserted when 0.
- wr_en  in  1  MEM-stage store request; level, held while ready=0.
- rd_en  in  1  MEM-stage load request; level, held while ready=0.
- address  in  32  byte address, word aligned.
- write_data  in  32  store data.
- read_data  out  32  load result, registered.
- ready  out  1  high when the pipeline may advance.
- sram_addr  out  ADDR_W  SRAM half-word address.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_oe  out  1  output enable for the top-level tristate on the DQ pin.
- sram_dq_in  in  16  data read from SRAM.

Behaviour:
- Reset (rst=0 at a clk edge) forces the following, from any state including mid-transfer:
  - state=IDLE, counter=0, read_data=0;
  - sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
  - ready=1 while rst=0.
- Address mapping: word = (address − MEM_BASE) >> 2, truncated to ADDR_W−1 bits.
  - Low half at sram_addr = {word, 1'b0}; high half at {word, 1'b1}.
- States: IDLE → LOW → HIGH → DONE → IDLE.
- IDLE:
  - ready = ~(wr_en | rd_en), combinational.
  - On a clk edge with a request present: latch address, write_data and op; op = write if wr_en, else read. wr_en wins when both are high.
  - Then go to LOW with counter = 0.
- LOW and HIGH:
  - Each state lasts exactly HALF_CYCLES cycles; counter runs 0..HALF_CYCLES−1, then the state advances and counter clears.
  - sram_addr is held constant for the whole state.
  - Write op: sram_dq_oe=1; sram_dq_out = latched data[15:0] in LOW, [31:16] in HIGH.
    - sram_we_n=0 for counter < HALF_CYCLES−1.
    - sram_we_n=1 in the final cycle, so the address never changes while the strobe is low.
  - Read op: sram_dq_oe=0, sram_we_n=1.
    - read_data[15:0] ← sram_dq_in at the clk edge ending the last LOW cycle.
    - read_data[31:16] ← sram_dq_in at the clk edge ending the last HIGH cycle.
  - ready=0 throughout LOW and HIGH.
- DONE:
  - One cycle, ready=1, SRAM idle (we_n=1, oe=0). Next state is IDLE unconditionally.
  - This prevents the same held request from being re-accepted on the edge where the pipeline advances.
- Latency: request first seen in cycle 0; ready=1 in cycle 1 + 2·HALF_CYCLES (cycle 7 at the default).
- read_data holds its value until the next read completes; writes do not modify it.
- A request deasserted mid-transfer does not abort it: the sequence completes and passes through DONE.
- Back-to-back requests: a new request is accepted no earlier than the IDLE cycle after DONE.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - MEM_BASE;
  - the SRAM data width constant of 16.
- One sub-module, sram_wait_counter: a 4-bit up-counter with clear and a `last` flag at HALF_CYCLES−1. It is instantiated once.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-write (state LOW) → next cycle ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Write 0xDEADBEEF to address 1032:
  - sram_addr=4 for cycles 1–3 with dq_out=0xBEEF, we_n=0,0,1;
  - sram_addr=5 for cycles 4–6 with dq_out=0xDEAD;
  - ready=1 only in cycle 7.
- Read from 1032 with the SRAM model returning 0xBEEF at addr 4 and 0xDEAD at addr 5 → read_data=0xDEADBEEF from cycle 7; we_n stays 1 and oe stays 0 throughout.
- wr_en=rd_en=1 together → write sequence executes and read_data is unchanged.
- Request dropped after cycle 2 → sequence still completes; ready=1 in cycle 7; state back in IDLE in cycle 8.
- Back-to-back reads held continuously → second sram_addr activity starts in cycle 9; exactly two DONE pulses within 16 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
package mem_pkg;

  localparam int unsigned MEM_BASE = 1024;
  localparam int unsigned SRAM_DW  = 16;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CNT_W    = 4;

  // Controller sequence: accept, low half, high half, one-cycle release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } ctrlStateT;

  // Request captured from the MEM stage when an access is accepted.
  typedef struct packed {
    logic              isWrite;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] writeData;
  } memReqT;

  // Byte address to SRAM word index, before truncation to the SRAM size.
  function automatic logic [WORD_W-1:0] wordIndex(
    input logic [WORD_W-1:0] byteAddr,
    input logic [WORD_W-1:0] base
  );
    return (byteAddr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-word cycle counter; flags the final cycle of a transfer.
module sram_wait_counter
  import mem_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HALF_CYCLES - 1);

  // Count up while enabled; clear has priority so a new half starts at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Final cycle of the current half-word transfer.
  always_comb begin
    last = (count == LAST_COUNT);
  end

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit async SRAM transfers.
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 3,
  parameter int unsigned MEM_BASE    = mem_pkg::MEM_BASE,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  write_data,
  output logic [WORD_W-1:0]  read_data,
  output logic               ready,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic               sram_we_n,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in
);

  localparam int unsigned      WORD_AW    = ADDR_W - 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HALF_CYCLES - 1);

  ctrlStateT state;
  ctrlStateT nextState;
  memReqT    req;

  logic             reqPresent;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             countLast;
  logic             countClear;
  logic             countEnable;

  logic                isWriteNext;
  logic [WORD_W-1:0]   dataNext;
  logic [WORD_AW-1:0]  wordNext;
  logic [ADDR_W-1:0]   addrD;
  logic                weND;
  logic                oeD;
  logic [SRAM_DW-1:0]  dqOutD;

  // Counter runs only inside a half-word transfer and restarts at each half.
  always_comb begin
    reqPresent  = wr_en | rd_en;
    countEnable = (state == LOW) || (state == HIGH);
    countClear  = !countEnable || countLast;
  end

  sram_wait_counter #(
    .HALF_CYCLES(HALF_CYCLES)
  ) waitCounter (
    .clk   (clk),
    .rst   (rst),
    .clear (countClear),
    .enable(countEnable),
    .count (count),
    .last  (countLast)
  );

  // Capture the request on acceptance; writes take priority over reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req <= '0;
    end else if ((state == IDLE) && reqPresent) begin
      req <= memReqT'{isWrite: wr_en, address: address, writeData: write_data};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: DONE always returns to IDLE so a held request is not re-taken.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (reqPresent) nextState = LOW;
      LOW:     if (countLast)  nextState = HIGH;
      HIGH:    if (countLast)  nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs: ready decode, plus next values of the registered SRAM pins.
  always_comb begin
    ready       = 1'b0;
    isWriteNext = req.isWrite;
    dataNext    = req.writeData;
    wordNext    = WORD_AW'(wordIndex(req.address, MEM_BASE));
    countNext   = count + CNT_W'(1);
    addrD       = '0;
    weND        = 1'b1;
    oeD         = 1'b0;
    dqOutD      = '0;

    case (state)
      IDLE:    ready = !reqPresent;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
    if (!rst) ready = 1'b1;

    if (state == IDLE) begin
      isWriteNext = wr_en;
      dataNext    = write_data;
      wordNext    = WORD_AW'(wordIndex(address, MEM_BASE));
    end

    if (nextState != state) countNext = '0;

    // Strobe released in the last cycle of each half so address stays stable.
    if ((nextState == LOW) || (nextState == HIGH)) begin
      addrD = {wordNext, (nextState == HIGH)};
      if (isWriteNext) begin
        oeD    = 1'b1;
        weND   = (countNext == LAST_COUNT);
        dqOutD = (nextState == HIGH) ? dataNext[WORD_W-1:SRAM_DW]
                                     : dataNext[SRAM_DW-1:0];
      end
    end
  end

  // Registered SRAM pins, glitch-free toward the device.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_dq_out <= '0;
    end else begin
      sram_addr   <= addrD;
      sram_we_n   <= weND;
      sram_dq_oe  <= oeD;
      sram_dq_out <= dqOutD;
    end
  end

  // Load data assembled from the last cycle of each half; held between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      read_data <= '0;
    end else if (!req.isWrite && countLast) begin
      if (state == LOW) begin
        read_data[SRAM_DW-1:0] <= sram_dq_in;
      end else if (state == HIGH) begin
        read_data[WORD_W-1:SRAM_DW] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed cases followed by random traffic.
module tb_sram_ctrl;

  localparam int          H    = 3;
  localparam int          AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  logic [15:0] sramMem [0:(1<<AW)-1];
  logic [31:0] expMem [logic [16:0]];
  logic [31:0] expRd = 32'h0;

  int checks     = 0;
  int failures   = 0;
  int readyHighs = 0;

  sram_ctrl #(
    .HALF_CYCLES(H),
    .MEM_BASE   (1024),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = sramMem[sram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Device write happens while the strobe is low; then advance one cycle.
  task automatic nextCycle();
    if (!sram_we_n && sram_dq_oe) sramMem[sram_addr] = sram_dq_out;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    wr_en      = wr;
    rd_en      = rd;
    address    = a;
    write_data = d;
  endtask

  task automatic preload(input logic [16:0] key, input logic [31:0] val);
    sramMem[{key, 1'b0}] = val[15:0];
    sramMem[{key, 1'b1}] = val[31:16];
    expMem[key] = val;
  endtask

  task automatic chkIdle(input string tag, input logic eRdy);
    chk({tag, ".ready"}, 32'(ready), 32'(eRdy));
    chk({tag, ".we_n"}, 32'(sram_we_n), 32'h1);
    chk({tag, ".oe"}, 32'(sram_dq_oe), 32'h0);
    chk({tag, ".addr"}, 32'(sram_addr), 32'h0);
    chk({tag, ".dq"}, 32'(sram_dq_out), 32'h0);
    chk({tag, ".rdata"}, read_data, expRd);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      drive(1'b0, 1'b0, $urandom, $urandom);
      #1;
      chkIdle($sformatf("%s.i%0d", tag, i), 1'b1);
    end
  endtask

  // One access: expected pins per cycle follow from the transfer timeline.
  task automatic runTxn(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input int hold, input string tag);
    logic [31:0] w;
    logic [16:0] key;
    logic [17:0] lo;
    logic [17:0] eAddr;
    logic [31:0] oldRd, newRd, eRd, eDq;
    logic        eWe, eOe, eRdy;
    int          k, half, ph;
    w     = (addr - BASE) >> 2;
    key   = 17'(w);
    lo    = 18'(w * 32'd2);
    oldRd = expRd;
    newRd = wr ? oldRd : (expMem.exists(key) ? expMem[key] : 32'h0);
    for (int c = 0; c <= 2*H+1; c++) begin
      nextCycle();
      if (c < hold) drive(wr, rd, addr, data);
      else          drive(1'b0, 1'b0, $urandom, $urandom);
      #1;
      eRdy  = (c == 2*H+1);
      eAddr = '0;
      eWe   = 1'b1;
      eOe   = 1'b0;
      eDq   = 32'h0;
      if (c >= 1 && c <= 2*H) begin
        k     = c - 1;
        half  = k / H;
        ph    = k % H;
        eAddr = lo + 18'(half);
        if (wr) begin
          eOe = 1'b1;
          eWe = (ph == H - 1);
          eDq = (half == 1) ? {16'h0, data[31:16]} : {16'h0, data[15:0]};
        end
      end
      if (wr || c <= H) eRd = oldRd;
      else if (c <= 2*H) eRd = {oldRd[31:16], newRd[15:0]};
      else eRd = newRd;
      if (ready) readyHighs++;
      chk($sformatf("%s.c%0d.ready", tag, c), 32'(ready), 32'(eRdy));
      chk($sformatf("%s.c%0d.addr", tag, c), 32'(sram_addr), 32'(eAddr));
      chk($sformatf("%s.c%0d.we_n", tag, c), 32'(sram_we_n), 32'(eWe));
      chk($sformatf("%s.c%0d.oe", tag, c), 32'(sram_dq_oe), 32'(eOe));
      chk($sformatf("%s.c%0d.dq", tag, c), 32'(sram_dq_out), eDq);
      chk($sformatf("%s.c%0d.rdata", tag, c), read_data, eRd);
    end
    if (wr) expMem[key] = data;
    expRd = newRd;
  endtask

  initial begin
    int r0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < (1 << AW); i++) sramMem[i] = 16'h0;
    for (int i = 0; i < 16; i++) preload(17'(i), $urandom);
    preload(17'h1FFFF, 32'hA5A5_5A5A);

    // Power-up reset
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      chkIdle($sformatf("por%0d", i), 1'b1);
    end
    rst = 1'b1;
    idle(2, "post_por");

    // Directed: write then read back at 1032 (SRAM word 2, half addrs 4/5)
    runTxn(1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 99, "wr1032");
    idle(1, "g1");
    runTxn(1'b0, 1'b1, 32'd1032, 32'h0, 99, "rd1032");
    idle(1, "g2");

    // Both requests high: write wins, read_data untouched
    runTxn(1'b1, 1'b1, 32'd1036, 32'h1234_5678, 99, "both");
    idle(1, "g3");

    // Request dropped after cycle 2; next request accepted in cycle 8
    runTxn(1'b0, 1'b1, 32'd1040, 32'h0, 3, "drop");

    // Back-to-back held reads: exactly two ready pulses over 16 cycles
    r0 = readyHighs;
    runTxn(1'b0, 1'b1, 32'd1036, 32'h0, 99, "b2bA");
    runTxn(1'b0, 1'b1, 32'd1032, 32'h0, 99, "b2bB");
    chk("b2b.donePulses", 32'(readyHighs - r0), 32'd2);
    idle(1, "g4");

    // Address below MEM_BASE wraps to the top of the SRAM
    runTxn(1'b0, 1'b1, 32'd1020, 32'h0, 99, "wrap");
    idle(1, "g5");

    // Reset asserted for 2 cycles in the middle of a write's LOW phase
    nextCycle();
    drive(1'b1, 1'b0, 32'd1424, 32'hCAFE_F00D);
    #1;
    chk("rstw.c0.ready", 32'(ready), 32'h0);
    nextCycle();
    #1;
    chk("rstw.c1.we_n", 32'(sram_we_n), 32'h0);
    chk("rstw.c1.addr", 32'(sram_addr), 32'd200);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rstw.c1.readyInRst", 32'(ready), 32'h1);
    expRd = 32'h0;
    nextCycle();
    #1;
    chkIdle("rstw.c2", 1'b1);
    nextCycle();
    rst = 1'b1;
    #1;
    chkIdle("rstw.c3", 1'b1);

    // Random traffic against the word-level model
    for (int t = 0; t < 24; t++) begin
      int unsigned sel, wIdx, gap;
      int          hold;
      logic        wr, rd;
      sel  = $urandom_range(0, 3);
      wr   = (sel == 0) || (sel == 2);
      rd   = (sel != 0);
      wIdx = $urandom_range(0, 15);
      hold = ($urandom_range(0, 1) == 1) ? 99 : int'($urandom_range(1, 2*H+1));
      runTxn(wr, rd, BASE + 32'(wIdx * 4), $urandom, hold, $sformatf("rnd%0d", t));
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(int'(gap), $sformatf("rg%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
